// File: rtl/xdisp_pkg.sv
// Shared constants and state encoding for the 7-segment display front end.
// Message codes, register map and magnitude limit live here.
package xdisp_pkg;

   localparam logic [1:0] MSG_NUM = 2'b00;
   localparam logic [1:0] MSG_OP  = 2'b01;
   localparam logic [1:0] MSG_VAL = 2'b10;
   localparam logic [1:0] MSG_ERR = 2'b11;

   localparam logic [1:0] ADDR_VALUE = 2'd0;
   localparam logic [1:0] ADDR_MSG   = 2'd1;
   localparam logic [1:0] ADDR_DOT   = 2'd2;

   localparam int MAG_MAX = 255;

   typedef enum logic {
      NUM  = 1'b0,
      HOLD = 1'b1
   } state_e;

endpackage

// File: rtl/xdisp_sgnmag.sv
// Signed two's-complement to 8-bit sign/magnitude conversion.
// Works in DATA_W+1 bits so the most-negative input cannot wrap.
module xdisp_sgnmag
   import xdisp_pkg::*;
#(
   parameter int DATA_W = 16
) (
   input  logic [DATA_W-1:0] val,
   output logic [7:0]        mag,
   output logic              neg,
   output logic              ovf
);

   logic [DATA_W:0] ext;
   logic [DATA_W:0] mag_full;

   always_comb begin
      ext      = {val[DATA_W-1], val};
      mag_full = val[DATA_W-1] ? -ext : ext;
      mag      = mag_full[7:0];
      neg      = val[DATA_W-1] & (mag_full != '0);
      ovf      = mag_full > (DATA_W+1)'(MAG_MAX);
   end

endmodule

// File: rtl/xdisp_ctrl.sv
// Bus-write front end for the 7-segment decoder: value conversion,
// timed status messages and the decoder write strobe.
module xdisp_ctrl
   import xdisp_pkg::*;
#(
   parameter int          DATA_W      = 16,
   parameter int unsigned HOLD_CYCLES = 50_000_000
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              sel,
   input  logic              we,
   input  logic [1:0]        addr,
   input  logic [DATA_W-1:0] wdata,
   output logic              hold_active,
   output logic              disp_we,
   output logic              disp_sel,
   output logic [7:0]        disp_bin,
   output logic              disp_sgn,
   output logic [1:0]        disp_dot,
   output logic [1:0]        disp_msg
);

   localparam int CNT_W = (HOLD_CYCLES > 1) ? $clog2(HOLD_CYCLES) : 1;
   localparam logic [CNT_W-1:0] CNT_LOAD =
      (HOLD_CYCLES == 0) ? '0 : CNT_W'(HOLD_CYCLES - 1);

   state_e           state_q, state_d;
   logic [CNT_W-1:0] cnt_q, cnt_d;
   logic [1:0]       code_q, code_d;
   logic             val_ok;
   logic             wr;
   logic [7:0]       mag;
   logic             neg;
   logic             ovf;

   assign wr = sel & we;

   xdisp_sgnmag #(
      .DATA_W (DATA_W)
   ) u_sgnmag (
      .val (wdata),
      .mag (mag),
      .neg (neg),
      .ovf (ovf)
   );

   // Timeout first, so an accepted write in the same cycle overrides it
   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      code_d  = code_q;
      val_ok  = 1'b0;
      if (state_q == HOLD && HOLD_CYCLES != 0) begin
         if (cnt_q == '0) state_d = NUM;
         else             cnt_d   = cnt_q - CNT_W'(1);
      end
      if (wr) begin
         unique case (1'b1)
            addr == ADDR_VALUE: begin
               if (ovf) begin
                  state_d = HOLD;
                  code_d  = MSG_ERR;
                  cnt_d   = CNT_LOAD;
               end else begin
                  val_ok  = 1'b1;
                  state_d = NUM;
               end
            end
            addr == ADDR_MSG: begin
               if (wdata[1:0] == MSG_NUM) begin
                  state_d = NUM;
                  code_d  = MSG_NUM;
               end else begin
                  state_d = HOLD;
                  code_d  = wdata[1:0];
                  cnt_d   = CNT_LOAD;
               end
            end
            default: ;
         endcase
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q     <= NUM;
         cnt_q       <= '0;
         code_q      <= MSG_NUM;
         hold_active <= 1'b0;
         disp_we     <= 1'b0;
         disp_sel    <= 1'b0;
         disp_bin    <= '0;
         disp_sgn    <= 1'b0;
         disp_dot    <= '0;
         disp_msg    <= MSG_NUM;
      end else begin
         state_q     <= state_d;
         cnt_q       <= cnt_d;
         code_q      <= code_d;
         disp_we     <= val_ok;
         disp_sel    <= val_ok;
         hold_active <= (state_d == HOLD);
         disp_msg    <= (state_d == HOLD) ? code_d : MSG_NUM;
         if (val_ok) begin
            disp_bin <= mag;
            disp_sgn <= neg;
         end
         if (wr && addr == ADDR_DOT) disp_dot <= wdata[1:0];
      end
   end

endmodule

// File: tb/tb_xdisp_ctrl.sv
// Directed bench for xdisp_ctrl with a per-cycle reference model
// tracking remaining message time and the decoder's shown value.
module tb_xdisp_ctrl;

   localparam int H = 8;

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic        sel = 1'b0;
   logic        we = 1'b0;
   logic [1:0]  addr = '0;
   logic [15:0] wdata = '0;
   logic        hold_active;
   logic        disp_we;
   logic        disp_sel;
   logic [7:0]  disp_bin;
   logic        disp_sgn;
   logic [1:0]  disp_dot;
   logic [1:0]  disp_msg;

   int checks = 0;
   int errors = 0;

   xdisp_ctrl #(
      .DATA_W      (16),
      .HOLD_CYCLES (H)
   ) dut (
      .clk         (clk),
      .rst_n       (rst_n),
      .sel         (sel),
      .we          (we),
      .addr        (addr),
      .wdata       (wdata),
      .hold_active (hold_active),
      .disp_we     (disp_we),
      .disp_sel    (disp_sel),
      .disp_bin    (disp_bin),
      .disp_sgn    (disp_sgn),
      .disp_dot    (disp_dot),
      .disp_msg    (disp_msg)
   );

   always #5 clk = ~clk;

   // Reference model: what the decoder shows and how long a message remains
   int       m_left;
   int       m_bin;
   int       m_sgn;
   int       m_dot;
   int       m_code;
   int       m_we;
   int       mv;
   int       mmag;

   always @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         m_left = 0; m_bin = 0; m_sgn = 0;
         m_dot = 0; m_code = 0; m_we = 0;
      end else begin
         m_we = 0;
         if (m_left > 0) m_left = m_left - 1;
         if (sel && we) begin
            case (addr)
               2'd0: begin
                  mv   = int'($signed(wdata));
                  mmag = (mv < 0) ? -mv : mv;
                  if (mmag <= 255) begin
                     m_bin  = mmag;
                     m_sgn  = (mv < 0) ? 1 : 0;
                     m_we   = 1;
                     m_left = 0;
                  end else begin
                     m_code = 3;
                     m_left = H;
                  end
               end
               2'd1: begin
                  if (wdata[1:0] == 2'b00) m_left = 0;
                  else begin
                     m_code = int'(wdata[1:0]);
                     m_left = H;
                  end
               end
               2'd2: m_dot = int'(wdata[1:0]);
               default: ;
            endcase
         end
      end
   end

   task automatic chk(input string name, input int act, input int exp);
      checks++;
      if (act != exp) begin
         errors++;
         $display("FAIL %s: got %0d expected %0d at %0t",
                  name, act, exp, $time);
      end
   endtask

   always @(negedge clk) begin
      if (rst_n) begin
         chk("m_we",   int'(disp_we),     m_we);
         chk("m_sel",  int'(disp_sel),    m_we);
         chk("m_bin",  int'(disp_bin),    m_bin);
         chk("m_sgn",  int'(disp_sgn),    m_sgn);
         chk("m_dot",  int'(disp_dot),    m_dot);
         chk("m_msg",  int'(disp_msg),    (m_left > 0) ? m_code : 0);
         chk("m_hold", int'(hold_active), (m_left > 0) ? 1 : 0);
      end
   end

   task automatic wr(input logic [1:0] a, input logic [15:0] d);
      @(negedge clk);
      sel = 1'b1; we = 1'b1; addr = a; wdata = d;
   endtask

   task automatic idle(input int n);
      for (int i = 0; i < n; i++) begin
         @(negedge clk);
         sel = 1'b0; we = 1'b0; addr = '0; wdata = '0;
      end
   endtask

   task automatic chk_zero(input string tag);
      chk({tag, "_we"},   int'(disp_we),     0);
      chk({tag, "_sel"},  int'(disp_sel),    0);
      chk({tag, "_bin"},  int'(disp_bin),    0);
      chk({tag, "_sgn"},  int'(disp_sgn),    0);
      chk({tag, "_dot"},  int'(disp_dot),    0);
      chk({tag, "_msg"},  int'(disp_msg),    0);
      chk({tag, "_hold"}, int'(hold_active), 0);
   endtask

   // Count cycles with a message shown, bounded by a cycle budget
   task automatic count_msg(input int code, output int n);
      n = 0;
      for (int i = 0; i < 30; i++) begin
         idle(1);
         if (int'(disp_msg) == code && hold_active) n++;
      end
   endtask

   int n;

   initial begin
      #1 chk_zero("rst");
      #20 rst_n = 1'b1;
      idle(2);
      chk_zero("post_rst");

      wr(2'd0, 16'hFFF9); idle(1);
      chk("v1_we", int'(disp_we), 1);
      chk("v1_sel", int'(disp_sel), 1);
      chk("v1_bin", int'(disp_bin), 7);
      chk("v1_sgn", int'(disp_sgn), 1);
      idle(1);
      chk("v1_we_low", int'(disp_we), 0);
      wr(2'd0, 16'h00FF); idle(1);
      chk("v2_bin", int'(disp_bin), 255);
      chk("v2_sgn", int'(disp_sgn), 0);

      wr(2'd0, 16'h0100); idle(1);
      chk("ovf_msg", int'(disp_msg), 3);
      chk("ovf_we", int'(disp_we), 0);
      chk("ovf_bin", int'(disp_bin), 255);
      n = (disp_msg == 2'b11) ? 1 : 0;
      begin
         int rest;
         count_msg(3, rest);
         chk("ovf_len", n + rest, 8);
      end
      wr(2'd0, 16'h8000); idle(1);
      chk("min_msg", int'(disp_msg), 3);
      chk("min_bin", int'(disp_bin), 255);
      begin
         int rest;
         count_msg(3, rest);
         chk("min_len", 1 + rest, 8);
      end
      chk("min_end", int'(disp_msg), 0);

      wr(2'd1, 16'h0001); idle(3);
      chk("op_msg", int'(disp_msg), 1);
      wr(2'd0, 16'h0005); idle(1);
      chk("op_cut_msg", int'(disp_msg), 0);
      chk("op_cut_we", int'(disp_we), 1);
      chk("op_cut_bin", int'(disp_bin), 5);
      wr(2'd1, 16'h0002); wr(2'd1, 16'h0000);
      chk("val_msg", int'(disp_msg), 2);
      idle(1);
      chk("num_msg", int'(disp_msg), 0);
      chk("num_hold", int'(hold_active), 0);

      wr(2'd1, 16'h0003); idle(7);
      chk("err_last", int'(disp_msg), 3);
      wr(2'd1, 16'h0002);
      count_msg(2, n);
      chk("restart_len", n, 8);

      wr(2'd2, 16'h0002); idle(1);
      chk("dot_val", int'(disp_dot), 2);
      chk("dot_we", int'(disp_we), 0);
      chk("dot_msg", int'(disp_msg), 0);
      wr(2'd3, 16'hFFFF); idle(1);
      chk("a3_dot", int'(disp_dot), 2);
      chk("a3_bin", int'(disp_bin), 5);
      chk("a3_we", int'(disp_we), 0);

      wr(2'd0, 16'h0003); wr(2'd0, 16'hFFFC);
      chk("b2b1_we", int'(disp_we), 1);
      chk("b2b1_bin", int'(disp_bin), 3);
      idle(1);
      chk("b2b2_we", int'(disp_we), 1);
      chk("b2b2_bin", int'(disp_bin), 4);
      chk("b2b2_sgn", int'(disp_sgn), 1);
      wr(2'd0, 16'h0000); idle(1);
      chk("zero_sgn", int'(disp_sgn), 0);
      chk("zero_we", int'(disp_we), 1);

      wr(2'd1, 16'h0001); idle(2);
      chk("pre_rst_msg", int'(disp_msg), 1);
      #2 rst_n = 1'b0;
      #1 chk_zero("mid_rst");
      idle(2);
      rst_n = 1'b1;
      idle(3);
      chk_zero("after_rst");

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
